// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// ----------------------
// Main control state machine for the multicycle RV32I datapath. It sequences
// fetch, decode, execute, memory and writeback over several cycles. One ALU
// and one unified memory port are shared across these steps. A memory access
// is held in place until mem_ready completes it.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   When defined, an unrecognised opcode in DECODE enters TRAP. TRAP raises
//   the extra `trap` output and stays there until reset. When undefined, an
//   unrecognised opcode behaves as a NOP (DECODE -> FETCH, no writes).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   opcode     in   instr[6:0] from the IR
//   funct3     in   instr[14:12] from the IR
//   ALU_flags  in   [0]=Z, [1]=N (signed lt), [2]=C (unsigned lt)
//   mem_ready  in   memory completes the current access this cycle
//   PCWrite    out  PC register enable
//   AdrSrc     out  memory address select: 0=PC, 1=ALUOut
//   MemWrite   out  memory write strobe
//   IRWrite    out  IR/OldPC load enable
//   ResultSrc  out  00=ALUOut, 01=MemData, 10=ALUResult
//   ALUSrcA    out  00=PC, 01=OldPC, 10=rs1
//   ALUSrcB    out  00=rs2, 01=Imm, 10=const 4
//   ALU_op     out  00=add, 01=sub/compare, 10=funct-decoded
//   ImmSrc     out  00=I, 01=S, 10=B, 11=J (decoded from opcode)
//   RegWrite   out  register file write enable
//   trap       out  (ILLEGAL_TRAP_EN only) 1 while in TRAP
//   state      out  current state, for debug

module multicycle_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [2:0]         ALU_flags,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALU_op,
    output logic [1:0]         ImmSrc,
    output logic               RegWrite,
`ifdef ILLEGAL_TRAP_EN
    output logic               trap,
`endif
    output logic [STATE_W-1:0] state
);

    // State encoding
    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(10);
`ifdef ILLEGAL_TRAP_EN
    localparam logic [STATE_W-1:0] S_TRAP     = STATE_W'(11);
`endif

    // RV32I major opcodes handled by this controller
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Mux select encodings
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] ALU_ADD     = 2'b00;
    localparam logic [1:0] ALU_SUB     = 2'b01;
    localparam logic [1:0] ALU_FUNCT   = 2'b10;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;

    // Unqualified write enables; reset gating is applied at the outputs
    logic pc_write_c;
    logic ir_write_c;
    logic mem_write_c;
    logic reg_write_c;

    // Branch condition from the compare flags, selected by funct3.
    // funct3 010/011 are not branch encodings and never take.
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic [2:0] flags);
        logic z;
        logic n;
        logic c;
        z = flags[0];
        n = flags[1];
        c = flags[2];
        case (f3)
            3'b000:  branch_taken = z;
            3'b001:  branch_taken = !z;
            3'b100:  branch_taken = n;
            3'b101:  branch_taken = !n;
            3'b110:  branch_taken = c;
            3'b111:  branch_taken = !c;
            default: branch_taken = 1'b0;
        endcase
    endfunction

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEMADR;
                    OP_RTYPE:  state_d = S_EXECR;
                    OP_ITYPE:  state_d = S_EXECI;
                    OP_JAL:    state_d = S_JAL;
                    OP_BRANCH: state_d = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
                    default:   state_d = S_TRAP;
`else
                    // Unrecognised opcode retires as a NOP
                    default:   state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                state_d = S_FETCH;
            end
            S_JAL: begin
                // rd <= OldPC + 4 is written through ALUWB
                state_d = S_ALUWB;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                // Only reset leaves TRAP
                state_d = S_TRAP;
            end
`endif
            default: begin
                // Unused encodings recover to FETCH
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode: Moore, except the FETCH handshake and the branch PC load
    always_comb begin
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALU_op      = 2'b00;
        case (state_q)
            S_FETCH: begin
                // PC+4 on the ALU; PC and IR load together when the read lands
                AdrSrc     = 1'b0;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ALU_op     = ALU_ADD;
                ResultSrc  = RES_ALURES;
                pc_write_c = mem_ready;
                ir_write_c = mem_ready;
            end
            S_DECODE: begin
                // Speculative branch/jump target into ALUOut
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ALU_op  = ALU_ADD;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALU_op  = ALU_ADD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = RES_MEMDATA;
                reg_write_c = 1'b1;
            end
            S_MEMWRITE: begin
                // Held level while stalled so the memory sees a stable strobe
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALU_op  = ALU_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALU_op  = ALU_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc   = RES_ALUOUT;
                reg_write_c = 1'b1;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC+4
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                ALU_op     = ALU_ADD;
                ResultSrc  = RES_ALUOUT;
                pc_write_c = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALU_op     = ALU_SUB;
                ResultSrc  = RES_ALUOUT;
                pc_write_c = branch_taken(funct3, ALU_flags);
            end
            default: begin
                // TRAP and unused encodings: everything idle
            end
        endcase
    end

    // Write enables are forced low for as long as reset is held
    assign PCWrite  = rst_n & pc_write_c;
    assign IRWrite  = rst_n & ir_write_c;
    assign MemWrite = rst_n & mem_write_c;
    assign RegWrite = rst_n & reg_write_c;

    // Immediate format follows the opcode directly
    always_comb begin
        case (opcode)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign trap = (state_q == S_TRAP);
`endif

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [2:0] ALU_flags;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALU_op, ImmSrc;
    logic [3:0] state;
`ifdef ILLEGAL_TRAP_EN
    logic       trap;
`endif

    int vectors = 0;
    int miscompares = 0;

    int path[$];     // expected sequence of states for one instruction
    bit mr_q[$];     // forced mem_ready values, one per cycle (random when empty)

    always #5 clk = ~clk;

    multicycle_control_fsm #(.STATE_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .funct3    (funct3),
        .ALU_flags (ALU_flags),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALU_op    (ALU_op),
        .ImmSrc    (ImmSrc),
        .RegWrite  (RegWrite),
`ifdef ILLEGAL_TRAP_EN
        .trap      (trap),
`endif
        .state     (state)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: expected sequence of steps for an instruction class.
    function automatic void build_path(input logic [6:0] opc);
        path.delete();
        path.push_back(0);
        path.push_back(1);
        if (opc == 7'b0000011) begin
            path.push_back(2); path.push_back(3); path.push_back(4);
        end else if (opc == 7'b0100011) begin
            path.push_back(2); path.push_back(5);
        end else if (opc == 7'b0110011) begin
            path.push_back(6); path.push_back(8);
        end else if (opc == 7'b0010011) begin
            path.push_back(7); path.push_back(8);
        end else if (opc == 7'b1101111) begin
            path.push_back(9); path.push_back(8);
        end else if (opc == 7'b1100011) begin
            path.push_back(10);
        end else begin
`ifdef ILLEGAL_TRAP_EN
            path.push_back(11);
`endif
        end
    endfunction

    function automatic bit ref_taken(input logic [2:0] f3, input logic [2:0] fl);
        bit z, n, c;
        z = fl[0]; n = fl[1]; c = fl[2];
        if (f3 == 3'b000) return z;
        if (f3 == 3'b001) return !z;
        if (f3 == 3'b100) return n;
        if (f3 == 3'b101) return !n;
        if (f3 == 3'b110) return c;
        if (f3 == 3'b111) return !c;
        return 1'b0;
    endfunction

    // Packed expectation: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALU_op}
    function automatic logic [12:0] ref_outs(input int st, input bit mr,
                                             input logic [2:0] fl, input logic [2:0] f3);
        bit pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0;
        logic [1:0] res = 2'b00, sa = 2'b00, sb = 2'b00, op = 2'b00;
        case (st)
            0:  begin sb = 2'b10; res = 2'b10; pcw = mr; irw = mr; end
            1:  begin sa = 2'b01; sb = 2'b01; end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  adr = 1;
            4:  begin res = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2'b10; op = 2'b10; end
            7:  begin sa = 2'b10; sb = 2'b01; op = 2'b10; end
            8:  rw = 1;
            9:  begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            10: begin sa = 2'b10; op = 2'b01; pcw = ref_taken(f3, fl); end
            default: ;
        endcase
        return {pcw, adr, mw, irw, rw, res, sa, sb, op};
    endfunction

    function automatic logic [1:0] ref_imm(input logic [6:0] opc);
        if (opc == 7'b0100011) return 2'b01;
        if (opc == 7'b1100011) return 2'b10;
        if (opc == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // Runs one instruction starting in FETCH, at posedge+1.
    // fl_rand=1 randomises ALU_flags every cycle, otherwise fl is held.
    task automatic run_instr(input string name, input logic [6:0] opc, input logic [2:0] f3,
                             input bit mr_rand, input bit fl_rand, input logic [2:0] fl);
        int idx = 0;
        int cyc = 0;
        int st;
        opcode = opc;
        funct3 = f3;
        build_path(opc);
        while (idx < path.size()) begin
            if (cyc > 60) begin
                check({name, "_timeout"}, 16'(idx), 16'(path.size()));
                return;
            end
            st = path[idx];
            if (mr_q.size() > 0) mem_ready = mr_q.pop_front();
            else mem_ready = mr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            ALU_flags = fl_rand ? 3'($urandom_range(0, 7)) : fl;
            @(negedge clk);
            check({name, "_state"}, 16'(state), 16'(st));
            check({name, "_outs"},
                  16'({PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALU_op}),
                  16'(ref_outs(st, mem_ready, ALU_flags, f3)));
            check({name, "_imm"}, 16'(ImmSrc), 16'(ref_imm(opc)));
`ifdef ILLEGAL_TRAP_EN
            check({name, "_trap"}, 16'(trap), 16'(st == 11));
`endif
            @(posedge clk);
            #1;
            cyc++;
            // Memory-waiting steps repeat until mem_ready completes them
            if (!((st == 0 || st == 3 || st == 5) && !mem_ready)) idx++;
        end
    endtask

    logic [6:0] legal_ops [6];

    initial begin
        legal_ops[0] = 7'b0000011; legal_ops[1] = 7'b0100011;
        legal_ops[2] = 7'b0110011; legal_ops[3] = 7'b0010011;
        legal_ops[4] = 7'b1101111; legal_ops[5] = 7'b1100011;

        rst_n = 1'b0;
        opcode = 7'b0010011;
        funct3 = 3'b000;
        ALU_flags = 3'b000;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        // Reset: FETCH with write enables forced off despite mem_ready=1
        check("rst_state", 16'(state), 16'd0);
        check("rst_outs",
              16'({PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALU_op}),
              16'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00}));
        mem_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed instructions
        run_instr("addi", 7'b0010011, 3'b000, 0, 0, 3'b000);
        mr_q = '{1, 1, 1, 0, 0, 1, 1};
        run_instr("lw_stall", 7'b0000011, 3'b010, 0, 0, 3'b000);
        run_instr("sw", 7'b0100011, 3'b010, 0, 0, 3'b000);
        run_instr("bne_nt", 7'b1100011, 3'b001, 0, 0, 3'b001);
        run_instr("bge_t", 7'b1100011, 3'b101, 0, 0, 3'b000);
        run_instr("bltu_t", 7'b1100011, 3'b110, 0, 0, 3'b100);
        run_instr("jal", 7'b1101111, 3'b000, 0, 0, 3'b000);
        run_instr("rtype", 7'b0110011, 3'b000, 0, 0, 3'b000);

        // Randomised instruction stream with memory stalls and random flags
        for (int i = 0; i < 80; i++) begin
            run_instr("rand", legal_ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                      1, 1, 3'b000);
        end

        // Asynchronous reset while a store is stalled in MEMWRITE
        opcode = 7'b0100011;
        mem_ready = 1'b1;
        @(posedge clk); #1;           // DECODE
        @(posedge clk); #1;           // MEMADR
        mem_ready = 1'b0;
        @(posedge clk); #1;           // MEMWRITE, stalled
        check("sw_stall_state", 16'(state), 16'd5);
        check("sw_stall_mw", 16'(MemWrite), 16'd1);
        #2;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("async_rst_state", 16'(state), 16'd0);
        check("async_rst_mw", 16'(MemWrite), 16'd0);
        check("async_rst_pcw_irw", 16'({PCWrite, IRWrite}), 16'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Unrecognised opcode
        run_instr("illegal", 7'b1111111, 3'b000, 0, 0, 3'b000);
`ifdef ILLEGAL_TRAP_EN
        // TRAP must hold with writes off regardless of mem_ready
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            check("trap_hold_state", 16'(state), 16'd11);
            check("trap_hold_flag", 16'(trap), 16'd1);
            check("trap_hold_we", 16'({PCWrite, IRWrite, MemWrite, RegWrite}), 16'd0);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("trap_rst", 16'(state), 16'd0);
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
`endif
        // Machine continues normally afterwards
        run_instr("post_addi", 7'b0010011, 3'b000, 0, 0, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main control state machine for the multicycle RV32I datapath. It replaces the single-cycle combinational decode and sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one unified memory port. It drives the datapath mux selects and write enables each cycle and stalls on a memory ready handshake.

Parameters:
STATE_W, 4, width of the state register and of the state debug output.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instr[6:0], taken from the IR
funct3  in  3  instr[14:12], taken from the IR
ALU_flags  in  3  [0]=Z (result zero), [1]=N (signed rs1<rs2), [2]=C (unsigned rs1<rs2)
mem_ready  in  1  memory completes the current access this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR/OldPC load enable
ResultSrc  out  2  00=ALUOut, 01=MemData, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1
ALUSrcB  out  2  00=rs2, 01=Imm, 10=const 4
ALU_op  out  2  00=add, 01=sub/compare, 10=funct-decoded
ImmSrc  out  2  00=I, 01=S, 10=B, 11=J (combinational from opcode, default 00)
RegWrite  out  1  register file write enable
state  out  STATE_W  current state, for debug

Behaviour:
- Moore outputs decoded from the state. The exceptions are PCWrite and IRWrite, which are also gated by mem_ready or the branch condition.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, JAL=9, BRANCH=10, TRAP=11.
- Reset: the state goes to FETCH asynchronously. While rst_n=0, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. Other outputs take their FETCH values. A reset mid-instruction abandons the instruction with no writes.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALU_op=00, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALU_op=00 (branch/jump target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BRANCH
  - other -> FETCH (see the optional feature)
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALU_op=00. Goes to MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready, then FETCH. MemWrite must stay stable while stalled.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALU_op=10, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALU_op=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALU_op=00, ResultSrc=00, PCWrite=1 (PC<=target), then ALUWB (rd<=OldPC+4).
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALU_op=01, ResultSrc=00. PCWrite=taken, evaluated on ALU_flags in the same cycle, then FETCH. Taken rules by funct3:
  - 000: Z
  - 001: !Z
  - 100: N
  - 101: !N
  - 110: C
  - 111: !C
  - 010/011: never taken
- Outside the listed states, all write enables are 0 and every mux select is 00.
- Instruction latency with mem_ready always 1:
  - lw 5 cycles
  - sw 4
  - R/I-type 4
  - jal 4
  - branch 3
- Each memory stall cycle adds 1.
- Unreachable encodings (12-15) return to FETCH on the next clock.

Optional Feature:
ILLEGAL_TRAP_EN. When defined:
- an unrecognised opcode in DECODE goes to TRAP;
- a 1-bit output port trap is added, and it is 1 only in TRAP;
- TRAP holds all write enables at 0 and stays in TRAP until rst_n is asserted.
When not defined:
- the trap port is absent;
- an unrecognised opcode executes as a NOP: DECODE -> FETCH with no register or memory write.

Test Plan:
- addi (0010011, funct3 000), mem_ready=1 -> state 0,1,7,8,0. RegWrite=1 only in cycle 4. ImmSrc=00.
- lw (0000011, funct3 010), mem_ready low for 2 cycles in MEMREAD -> state 0,1,2,3,3,3,4,0. AdrSrc=1 in MEMREAD. RegWrite with ResultSrc=01 in MEMWB.
- sw (0100011), mem_ready=1 -> state 0,1,2,5,0. MemWrite=1 for exactly one cycle. RegWrite never set. ImmSrc=01.
- Branch 1100011:
  - funct3 001 with ALU_flags=3'b001 -> PCWrite=0 in BRANCH;
  - funct3 101 with ALU_flags=3'b000 -> PCWrite=1;
  - funct3 110 with ALU_flags=3'b100 -> PCWrite=1.
- jal (1101111) -> state 0,1,9,8,0. PCWrite=1 in JAL. RegWrite=1 in ALUWB. ImmSrc=11.
- Reset and illegal opcode:
  - rst_n pulled low in MEMWRITE -> state=0 and MemWrite=0 immediately, without waiting for clk.
  - opcode 1111111 -> returns to FETCH with no writes (macro off), or reaches TRAP with trap=1 held (ILLEGAL_TRAP_EN).
